// File: rtl/dram_ctrl_if.sv
// rtl/dram_ctrl_if.sv - request/response handshake bundle between a client and dram_ctrl
// Ports (signals):
//   req_valid/req_ready : request handshake, transfer when both high on a CLK edge
//   req_we, req_be      : 1 = write / 0 = read; byte enables [0]=DATA[7:0], [1]=DATA[15:8]
//   req_addr, req_wdata : 10-bit word address, 16-bit write data
//   rsp_valid, rsp_rdata: one-cycle read response pulse and held read data
// Modports: master = client side, slave = controller side.

interface dram_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_be;
   logic [9:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_be, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_be, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/dram_ctrl.sv
// rtl/dram_ctrl.sv - valid/ready to RAS/CAS strobe sequencer with CAS-before-RAS refresh
// Ports:
//   CLK, RST_N   : clock (rising edge), synchronous active-low reset
//   bus (slave)  : request/response handshake bundle (dram_ctrl_if)
//   DATA         : bidirectional DRAM data bus, driven only in write ACT/CAS/RSH
//   MA           : DRAM word address, held from accept until the access leaves PRE
//   RAS_N, CAS_N, LWE_N, UWE_N, OE_N : active-low DRAM strobes
// Every DRAM-side output is a register loaded from the current state, so pins
// follow the FSM by exactly one cycle and all strobe edges land on CLK edges.

module dram_ctrl #(
   parameter int T_RCD      = 1,
   parameter int T_CAS      = 2,
   parameter int T_RP       = 2,
   parameter int REF_PERIOD = 256
) (
   input  logic         CLK,
   input  logic         RST_N,
   dram_ctrl_if.slave   bus,
   inout  wire  [15:0]  DATA,
   output logic [9:0]   MA,
   output logic         RAS_N,
   output logic         CAS_N,
   output logic         LWE_N,
   output logic         UWE_N,
   output logic         OE_N
);

   localparam int RW = $clog2(REF_PERIOD);

   typedef enum logic [2:0] {
      IDLE, ACT, CAS, RSH, PRE, REF_CAS, REF_RAS, REF_RSH
   } state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic [7:0]    r_tmr;
   logic [7:0]    w_tmr_nx;
   logic [RW-1:0] r_ref_cnt;
   logic          r_ref_pend;
   logic          w_ref_pend_nx;
   logic          w_ref_start;
   logic          w_accept;
   logic          r_ready;
   logic          r_we;
   logic [1:0]    r_be;
   logic [15:0]   r_wdata;
   logic [9:0]    r_ma;
   logic          r_ras_n, r_cas_n, r_lwe_n, r_uwe_n, r_oe_n;
   logic          r_data_oe;
   logic          r_rsp_valid;
   logic [15:0]   r_rdata;

   // r_tmr holds the remaining cycles of the current state minus one.
   always_comb begin
      w_state_nx  = r_state;
      w_tmr_nx    = (r_tmr != 8'd0) ? r_tmr - 8'd1 : r_tmr;
      w_accept    = 1'b0;
      w_ref_start = 1'b0;
      case (r_state)
         IDLE: begin
            // refresh wins; r_ready is already low whenever r_ref_pend is set
            if (r_ref_pend) begin
               w_state_nx  = REF_CAS;
               w_tmr_nx    = 8'd0;
               w_ref_start = 1'b1;
            end else if (bus.req_valid && r_ready) begin
               w_state_nx = ACT;
               w_tmr_nx   = 8'(T_RCD - 1);
               w_accept   = 1'b1;
            end
         end
         ACT:     if (r_tmr == 8'd0) begin w_state_nx = CAS;     w_tmr_nx = 8'(T_CAS - 1); end
         CAS:     if (r_tmr == 8'd0) begin w_state_nx = RSH;     w_tmr_nx = 8'd0;          end
         RSH:                        begin w_state_nx = PRE;     w_tmr_nx = 8'(T_RP - 1);  end
         PRE:     if (r_tmr == 8'd0) begin w_state_nx = IDLE;    w_tmr_nx = 8'd0;          end
         REF_CAS:                    begin w_state_nx = REF_RAS; w_tmr_nx = 8'(T_CAS - 1); end
         REF_RAS: if (r_tmr == 8'd0) begin w_state_nx = REF_RSH; w_tmr_nx = 8'd0;          end
         REF_RSH:                    begin w_state_nx = PRE;     w_tmr_nx = 8'(T_RP - 1);  end
         default:                    begin w_state_nx = IDLE;    w_tmr_nx = 8'd0;          end
      endcase
      // a fresh expiry is kept even if it coincides with the start of a refresh
      w_ref_pend_nx = (r_ref_cnt == '0) | (r_ref_pend & ~w_ref_start);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state     <= IDLE;
         r_tmr       <= 8'd0;
         r_ref_cnt   <= RW'(REF_PERIOD - 1);
         r_ref_pend  <= 1'b0;
         r_ready     <= 1'b0;
         r_we        <= 1'b0;
         r_be        <= 2'b00;
         r_wdata     <= 16'h0000;
         r_ma        <= 10'd0;
         r_ras_n     <= 1'b1;
         r_cas_n     <= 1'b1;
         r_lwe_n     <= 1'b1;
         r_uwe_n     <= 1'b1;
         r_oe_n      <= 1'b1;
         r_data_oe   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= 16'h0000;
      end else begin
         r_state    <= w_state_nx;
         r_tmr      <= w_tmr_nx;
         r_ref_cnt  <= (r_ref_cnt == '0) ? RW'(REF_PERIOD - 1) : r_ref_cnt - 1'b1;
         r_ref_pend <= w_ref_pend_nx;
         // registered from next-state so it equals (state==IDLE) & !ref_pending
         r_ready    <= (w_state_nx == IDLE) & ~w_ref_pend_nx;
         if (w_accept) begin
            r_we    <= bus.req_we;
            r_be    <= bus.req_be;
            r_wdata <= bus.req_wdata;
            r_ma    <= bus.req_addr;
         end
         r_ras_n     <= !(r_state inside {ACT, CAS, RSH, REF_RAS, REF_RSH});
         r_cas_n     <= !(r_state inside {CAS, REF_CAS, REF_RAS});
         r_lwe_n     <= !((r_state == CAS) && r_we && r_be[0]);
         r_uwe_n     <= !((r_state == CAS) && r_we && r_be[1]);
         r_oe_n      <= !((r_state inside {CAS, RSH}) && !r_we);
         r_data_oe   <= r_we && (r_state inside {ACT, CAS, RSH});
         // in RSH the pins still show the last CAS cycle, so this edge ends it
         r_rsp_valid <= (r_state == RSH) && !r_we;
         if ((r_state == RSH) && !r_we)
            r_rdata <= DATA;
      end
   end

   assign DATA          = r_data_oe ? r_wdata : 16'hzzzz;
   assign MA            = r_ma;
   assign RAS_N         = r_ras_n;
   assign CAS_N         = r_cas_n;
   assign LWE_N         = r_lwe_n;
   assign UWE_N         = r_uwe_n;
   assign OE_N          = r_oe_n;
   assign bus.req_ready = r_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_dram_ctrl.sv
// tb/tb_dram_ctrl.sv - directed self-checking bench for dram_ctrl with a behavioural DRAM
module tb_dram_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   wire  [15:0] DATA;
   logic [9:0]  MA;
   logic        RAS_N, CAS_N, LWE_N, UWE_N, OE_N;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   dram_ctrl_if bus ();

   dram_ctrl #(.T_RCD(1), .T_CAS(2), .T_RP(2), .REF_PERIOD(16)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus),
      .DATA  (DATA),
      .MA    (MA),
      .RAS_N (RAS_N),
      .CAS_N (CAS_N),
      .LWE_N (LWE_N),
      .UWE_N (UWE_N),
      .OE_N  (OE_N)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // DRAM model: byte-lane writes while RAS/CAS/WE are low, output while OE and RAS are low
   logic [15:0] mem [0:1023];
   assign DATA = (!OE_N && !RAS_N) ? mem[MA] : 16'hzzzz;
   always @(negedge CLK) begin
      if (!RAS_N && !CAS_N) begin
         if (!LWE_N) mem[MA][7:0]  <= DATA[7:0];
         if (!UWE_N) mem[MA][15:8] <= DATA[15:8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // per-access observations, cycle c = sampled after edge c (edge 0 = accept)
   int          acc_edge, n_rsp, rsp_lat, n_lwe, n_uwe, n_oe;
   logic [13:0] seq;
   logic        rdy6;
   logic [15:0] rsp_data;

   task automatic do_access(input logic we, input logic [1:0] be,
                            input logic [9:0] addr, input logic [15:0] wd);
      int w;
      n_rsp = 0; rsp_lat = 0; n_lwe = 0; n_uwe = 0; n_oe = 0; seq = '0; rdy6 = 1'b0;
      rsp_data = 16'h0000; acc_edge = -1;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_be = be;
      bus.req_addr = addr;  bus.req_wdata = wd;
      w = 0;
      while (!bus.req_ready && w < 64) begin
         @(negedge CLK);
         w++;
      end
      if (!bus.req_ready) begin
         check("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      @(negedge CLK);
      acc_edge = cyc;
      bus.req_valid = 1'b0;
      bus.req_we = ~we; bus.req_be = ~be; bus.req_addr = ~addr; bus.req_wdata = ~wd;
      for (int c = 1; c <= 7; c++) begin
         @(negedge CLK);
         seq = {seq[11:0], RAS_N, CAS_N};
         if (!LWE_N) n_lwe++;
         if (!UWE_N) n_uwe++;
         if (!OE_N)  n_oe++;
         if (bus.rsp_valid) begin
            n_rsp++;
            rsp_lat  = c;
            rsp_data = bus.rsp_rdata;
         end
         if (c == 6) rdy6 = bus.req_ready;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t1, t2, nref, w;
      logic pc, bad;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_be = 2'b00;
      bus.req_addr = 10'd0; bus.req_wdata = 16'h0000;

      // reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_strobes", {RAS_N, CAS_N, LWE_N, UWE_N, OE_N}, 5'b11111);
      check("rst_ma", MA, 10'd0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_rdata", bus.rsp_rdata, 16'h0000);
      check("rst_ready", bus.req_ready, 1'b0);
      RST_N = 1'b1;
      @(negedge CLK);
      check("ready_after_release", bus.req_ready, 1'b1);

      // full write with strobe timeline
      do_access(1'b1, 2'b11, 10'h001, 16'hA5A5);
      check("wr_ras_cas_seq", seq, {2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11});
      check("wr_ready_edge6", rdy6, 1'b1);
      check("wr11_lwe_cycles", n_lwe, 2);
      check("wr11_uwe_cycles", n_uwe, 2);
      check("wr11_no_rsp", n_rsp, 0);

      do_access(1'b0, 2'b00, 10'h001, 16'h0000);
      check("rd1_rsp_count", n_rsp, 1);
      check("rd1_latency", rsp_lat, 4);
      check("rd1_data", rsp_data, 16'hA5A5);
      check("rd1_oe_cycles", n_oe, 3);
      check("rd1_no_we", n_lwe + n_uwe, 0);

      // lower byte write
      do_access(1'b1, 2'b01, 10'h001, 16'h895A);
      check("wr01_lwe_cycles", n_lwe, 2);
      check("wr01_uwe_cycles", n_uwe, 0);
      do_access(1'b0, 2'b00, 10'h001, 16'h0000);
      check("rd2_data", rsp_data, 16'hA55A);

      // upper byte write
      do_access(1'b1, 2'b10, 10'h001, 16'h65C3);
      check("wr10_lwe_cycles", n_lwe, 0);
      check("wr10_uwe_cycles", n_uwe, 2);
      do_access(1'b0, 2'b00, 10'h001, 16'h0000);
      check("rd3_data", rsp_data, 16'h655A);

      // write with no byte enables leaves memory untouched
      do_access(1'b1, 2'b00, 10'h001, 16'hFFFF);
      check("wr00_we_cycles", n_lwe + n_uwe, 0);
      check("wr00_no_rsp", n_rsp, 0);
      do_access(1'b0, 2'b00, 10'h001, 16'h0000);
      check("rd4_data", rsp_data, 16'h655A);

      // periodic refresh on an idle bus
      t1 = 0; t2 = 0; nref = 0; bad = 1'b0; pc = CAS_N;
      for (int i = 0; i < 60 && nref < 2; i++) begin
         @(negedge CLK);
         if (!LWE_N || !UWE_N || !OE_N) bad = 1'b1;
         if (pc && !CAS_N && RAS_N) begin
            nref++;
            if (nref == 1) t1 = cyc; else t2 = cyc;
            @(negedge CLK);
            if (!LWE_N || !UWE_N || !OE_N) bad = 1'b1;
            check("ref_ras_follows_cas", {RAS_N, CAS_N}, 2'b00);
         end
         pc = CAS_N;
      end
      check("ref_found", nref, 2);
      check("ref_period", t2 - t1, 16);
      check("ref_we_oe_high", bad, 1'b0);

      // request raised in the cycle ref_pending sets: refresh goes first
      w = 0;
      while (cyc < t2 + 14 && w < 40) begin
         @(negedge CLK);
         w++;
      end
      check("coll_ready_low", bus.req_ready, 1'b0);
      do_access(1'b0, 2'b00, 10'h001, 16'h0000);
      check("coll_accept_edge", acc_edge - t2, 22);
      check("coll_rsp_count", n_rsp, 1);
      check("coll_data", rsp_data, 16'h655A);

      // reset pulse during the CAS window of a write
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_be = 2'b11;
      bus.req_addr = 10'h002; bus.req_wdata = 16'h1234;
      w = 0;
      while (!bus.req_ready && w < 64) begin
         @(negedge CLK);
         w++;
      end
      check("rstw_accept_ready", bus.req_ready, 1'b1);
      @(negedge CLK);
      bus.req_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("rstw_cas_low", CAS_N, 1'b0);
      RST_N = 1'b0;
      @(negedge CLK);
      check("rstw_strobes_high", {RAS_N, CAS_N, LWE_N, UWE_N, OE_N}, 5'b11111);
      check("rstw_rsp_valid", bus.rsp_valid, 1'b0);
      check("rstw_ready_in_reset", bus.req_ready, 1'b0);
      RST_N = 1'b1;
      @(negedge CLK);
      check("rstw_ready_after", bus.req_ready, 1'b1);
      n_rsp = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (bus.rsp_valid) n_rsp++;
      end
      check("rstw_no_rsp", n_rsp, 0);
      do_access(1'b0, 2'b00, 10'h001, 16'h0000);
      check("post_rst_rd_data", rsp_data, 16'h655A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
